// File: rtl/mc_pc_ir_regs_if.sv
// Bus bundle between the multicycle controller/datapath and the PC/IR state registers.
// Optional perf counter signals appear only when PERF_CNT_EN is defined.
interface mc_pc_ir_regs_if #(
    parameter int unsigned DATA_W = 32
);
    logic              PCWrite;
    logic              PCWriteCond;
    logic              IRWrite;
    logic [1:0]        PCSource;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] alu_out;
    logic              pc_misaligned;
`ifdef PERF_CNT_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       instr_cnt;
`endif

    modport master (
        output PCWrite, PCWriteCond, IRWrite, PCSource, zero,
        output alu_result, mem_rdata, rf_rd1, rf_rd2,
`ifdef PERF_CNT_EN
        input  cycle_cnt, instr_cnt,
`endif
        input  pc, instr, opcode, func, mdr, a_reg, b_reg, alu_out, pc_misaligned
    );

    modport slave (
        input  PCWrite, PCWriteCond, IRWrite, PCSource, zero,
        input  alu_result, mem_rdata, rf_rd1, rf_rd2,
`ifdef PERF_CNT_EN
        output cycle_cnt, instr_cnt,
`endif
        output pc, instr, opcode, func, mdr, a_reg, b_reg, alu_out, pc_misaligned
    );
endinterface

// File: rtl/mc_pc_ir_regs.sv
// Multicycle MIPS architectural state registers: PC, IR, MDR, A, B, ALUOut.
// Define PERF_CNT_EN to add free-running cycle_cnt and instr_cnt counters.
module mc_pc_ir_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DATA_W   = 32
) (
    input logic            clk,
    input logic            rst_n,
    mc_pc_ir_regs_if.slave bus
);
    typedef enum logic [1:0] {
        SRC_ALU    = 2'b00,
        SRC_ALUOUT = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_REG    = 2'b11
    } pc_src_e;

    logic              pc_en;
    logic [DATA_W-1:0] next_pc;

    assign pc_en = bus.PCWrite | (bus.PCWriteCond & bus.zero);

    always_comb begin
        next_pc = 'x;
        case (bus.PCSource)
            SRC_ALU:    next_pc = bus.alu_result;
            SRC_ALUOUT: next_pc = bus.alu_out;
            SRC_JUMP:   next_pc = {bus.pc[DATA_W-1:DATA_W-4], bus.instr[25:0], 2'b00};
            SRC_REG:    next_pc = bus.a_reg;
            default:    next_pc = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc            <= RESET_PC;
            bus.instr         <= '0;
            bus.mdr           <= '0;
            bus.a_reg         <= '0;
            bus.b_reg         <= '0;
            bus.alu_out       <= '0;
            bus.pc_misaligned <= 1'b0;
        end else begin
            bus.mdr     <= bus.mem_rdata;
            bus.a_reg   <= bus.rf_rd1;
            bus.b_reg   <= bus.rf_rd2;
            bus.alu_out <= bus.alu_result;
            if (bus.IRWrite)
                bus.instr <= bus.mem_rdata;
            if (pc_en) begin
                bus.pc <= next_pc;
                // Misaligned targets are still loaded; the flag is sticky until reset.
                if (next_pc[1:0] != 2'b00)
                    bus.pc_misaligned <= 1'b1;
            end
        end
    end

    assign bus.opcode = bus.instr[31:26];
    assign bus.func   = bus.instr[5:0];

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (bus.IRWrite)
                instr_q <= instr_q + 32'd1;
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.instr_cnt = instr_q;
`endif

    pc_src_known: assert property (@(posedge clk) disable iff (!rst_n)
        pc_en |-> !$isunknown(bus.PCSource));

endmodule
